// File: rtl/mem_arb_pkg.sv
// Shared types for the port-B arbiter. DATA_WIDTH normally comes from Constants.vh;
// a 32-bit fallback keeps this slice self-contained. Optional macro: MEM_ARB_RR_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mem_arb_pkg;

    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_LD = 1'b1} owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    localparam int MEM_ARB_LAT = 2;

    function automatic rd_tag_t make_tag(input logic valid, input owner_t owner);
        rd_tag_t t;
        t.valid = valid;
        t.owner = owner;
        return t;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// LAT-deep shift register of read tags; the tail lines up with the memory's
// registered read data.
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int LAT = MEM_ARB_LAT
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            rd_tag_t stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) stage_reg <= '0;
                    else     stage_reg <= tag_in;
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) stage_reg <= '0;
                    else     stage_reg <= g_stage[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign tag_out = g_stage[LAT-1].stage_reg;

endmodule

// File: rtl/mem_portb_arbiter.sv
// Port-B arbiter/sequencer between CPU load/store and UART loader, with loader lock.
// MEM_ARB_RR_EN selects round-robin on ties; otherwise the loader has fixed priority.
module mem_portb_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int LAT    = MEM_ARB_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [`DATA_WIDTH-1:0] cpu_wdata,
    input  logic                   ld_req,
    input  logic                   ld_we,
    input  logic [ADDR_W-1:0]      ld_addr,
    input  logic [`DATA_WIDTH-1:0] ld_wdata,
    input  logic                   ld_lock,
    output logic                   cpu_gnt,
    output logic                   ld_gnt,
    output logic                   cpu_rvalid,
    output logic                   ld_rvalid,
    output logic [`DATA_WIDTH-1:0] cpu_rdata,
    output logic [`DATA_WIDTH-1:0] ld_rdata,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [`DATA_WIDTH-1:0] mem_wdata,
    output logic                   mem_we,
    input  logic [`DATA_WIDTH-1:0] mem_rdata,
    output logic                   locked
);

    arb_state_t             state_reg, state_next;
    logic                   arb_mode;
    logic                   ld_wins;
    logic [ADDR_W-1:0]      addr_shadow_reg;
    logic [`DATA_WIDTH-1:0] wdata_shadow_reg;
    rd_tag_t                tag_in, tag_tail;

`ifdef MEM_ARB_RR_EN
    owner_t rr_ptr_reg;
`endif

    // The cycle that drops ld_lock is arbitrated as if already back in ARB.
    always_comb begin
        cpu_gnt    = 1'b0;
        ld_gnt     = 1'b0;
        state_next = state_reg;
        arb_mode   = (state_reg == ARB) || !ld_lock;
`ifdef MEM_ARB_RR_EN
        ld_wins    = ld_req && (!cpu_req || (rr_ptr_reg == OWN_LD));
`else
        ld_wins    = ld_req;
`endif
        if (!rst) begin
            if (arb_mode) begin
                ld_gnt  = ld_wins;
                cpu_gnt = cpu_req && !ld_wins;
            end else begin
                ld_gnt  = ld_req;
            end
        end
        if (arb_mode) begin
            state_next = (ld_gnt && ld_lock) ? LOCKED : ARB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ARB;
        else     state_reg <= state_next;
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= OWN_CPU;
        end else if (arb_mode && (cpu_gnt || ld_gnt)) begin
            rr_ptr_reg <= cpu_gnt ? OWN_LD : OWN_CPU;
        end
    end
`endif

    always_comb begin
        mem_addr  = addr_shadow_reg;
        mem_wdata = wdata_shadow_reg;
        mem_we    = 1'b0;
        if (ld_gnt) begin
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            mem_we    = ld_we;
        end else if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end
    end

    // Shadow keeps the memory address/data stable across idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_shadow_reg  <= '0;
            wdata_shadow_reg <= '0;
        end else begin
            addr_shadow_reg  <= mem_addr;
            wdata_shadow_reg <= mem_wdata;
        end
    end

    assign tag_in = make_tag((cpu_gnt && !cpu_we) || (ld_gnt && !ld_we),
                             ld_gnt ? OWN_LD : OWN_CPU);

    rd_tag_pipe #(.LAT(LAT)) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_tail)
    );

    assign cpu_rvalid = tag_tail.valid && (tag_tail.owner == OWN_CPU);
    assign ld_rvalid  = tag_tail.valid && (tag_tail.owner == OWN_LD);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;
    assign locked     = (state_reg == LOCKED);

endmodule

// File: tb/tb_mem_portb_arbiter.sv
// Directed bench for mem_portb_arbiter with a 2-cycle registered-read memory model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mem_portb_arbiter;

    localparam int AW = 14;
    localparam int DW = `DATA_WIDTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 0, cpu_we = 0, ld_req = 0, ld_we = 0, ld_lock = 0;
    logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, ld_wdata = '0;
    logic          cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_we, locked;
    logic [DW-1:0] cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    logic          bk_we = 1'b0;
    logic [AW-1:0] bk_addr = '0;
    logic [DW-1:0] bk_data = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd1, rd2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_portb_arbiter #(.ADDR_W(AW), .LAT(2)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_lock(ld_lock),
        .cpu_gnt(cpu_gnt), .ld_gnt(ld_gnt),
        .cpu_rvalid(cpu_rvalid), .ld_rvalid(ld_rvalid),
        .cpu_rdata(cpu_rdata), .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .locked(locked)
    );

    // Memory model: write at the edge, read-first, two registered read stages.
    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr] <= mem_wdata;
        else if (bk_we) mem[bk_addr]  <= bk_data;
        rd1 <= mem[mem_addr];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bk_we = 1'b1; bk_addr = a; bk_data = d;
        step();
        bk_we = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step(); step();
        @(negedge clk);
        n_checks++;
        if ({locked, mem_we, cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {locked, mem_we, cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid});
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_addr, mem_wdata, cpu_rdata, ld_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%h wdata=%h crd=%h lrd=%h want all 0",
                     mem_addr, mem_wdata, cpu_rdata, ld_rdata);
        end
        step();
        $display("test_reset done");
    endtask

    task automatic test_cpu_read();
        preload(14'h0010, 32'hDEADBEEF);
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ld_gnt, mem_we, mem_addr} !== {3'b100, 14'h0010}) begin
            n_fail++;
            $display("FAIL cpu_read_grant: got gnt=%b%b we=%b addr=%h want 10 0 0010",
                     cpu_gnt, ld_gnt, mem_we, mem_addr);
        end
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, ld_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL cpu_read_early: got rvalid=%b%b want 00", cpu_rvalid, ld_rvalid);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, ld_rvalid, cpu_rdata, ld_rdata} !== {2'b10, 32'hDEADBEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL cpu_read_data: got rvalid=%b%b crd=%h lrd=%h want 10 deadbeef 0",
                     cpu_rvalid, ld_rvalid, cpu_rdata, ld_rdata);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL cpu_read_after: got rvalid=%b rd=%h want 0 0", cpu_rvalid, cpu_rdata);
        end
        step();
        $display("test_cpu_read done");
    endtask

    task automatic test_write_then_read();
        ld_req = 1; ld_we = 1; ld_addr = 14'h0020; ld_wdata = 32'h12345678;
        @(negedge clk);
        n_checks++;
        if ({ld_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata} !== {3'b101, 14'h0020, 32'h12345678}) begin
            n_fail++;
            $display("FAIL wr_cycle0: got gnt=%b%b we=%b addr=%h wd=%h want 10 1 0020 12345678",
                     ld_gnt, cpu_gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        clear_inputs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0020;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_we, mem_addr} !== {2'b10, 14'h0020}) begin
            n_fail++;
            $display("FAIL rd_cycle1: got gnt=%b we=%b addr=%h want 1 0 0020",
                     cpu_gnt, mem_we, mem_addr);
        end
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if ({mem_we, cpu_rvalid, ld_rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL wr_no_rvalid: got we=%b rvalid=%b%b want 0 00", mem_we, cpu_rvalid, ld_rvalid);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h12345678}) begin
            n_fail++;
            $display("FAIL raw_data: got rvalid=%b rd=%h want 1 12345678", cpu_rvalid, cpu_rdata);
        end
        step();
        $display("test_write_then_read done");
    endtask

    task automatic test_contention();
        logic          own_ld [0:3];
        logic [AW-1:0] own_addr [0:3];
        logic          exp_ld;
        logic [DW-1:0] exp_data;
        for (int i = 0; i < 4; i++) begin
            preload(14'h0030 + AW'(i), 32'hA0000030 + DW'(i));
            preload(14'h0040 + AW'(i), 32'hA0000040 + DW'(i));
        end
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0030 + AW'(i);
                ld_req  = 1; ld_we  = 0; ld_addr  = 14'h0040 + AW'(i);
            end else begin
                clear_inputs();
            end
            @(negedge clk);
            if (i < 4) begin
`ifdef MEM_ARB_RR_EN
                exp_ld = (i % 2) == 1;
`else
                exp_ld = 1'b1;
`endif
                own_ld[i]   = exp_ld;
                own_addr[i] = exp_ld ? 14'h0040 + AW'(i) : 14'h0030 + AW'(i);
                n_checks++;
                if ({cpu_gnt, ld_gnt} !== {!exp_ld, exp_ld}) begin
                    n_fail++;
                    $display("FAIL contention_gnt[%0d]: got cpu/ld=%b%b want %b%b",
                             i, cpu_gnt, ld_gnt, !exp_ld, exp_ld);
                end
            end
            if (i >= 2) begin
                exp_ld   = own_ld[i-2];
                exp_data = 32'hA0000000 | DW'(own_addr[i-2]);
                n_checks++;
                if ({cpu_rvalid, ld_rvalid, cpu_rdata, ld_rdata} !==
                    {!exp_ld, exp_ld, exp_ld ? 32'h0 : exp_data, exp_ld ? exp_data : 32'h0}) begin
                    n_fail++;
                    $display("FAIL contention_rd[%0d]: got rv=%b%b crd=%h lrd=%h want rv=%b%b data=%h",
                             i, cpu_rvalid, ld_rvalid, cpu_rdata, ld_rdata, !exp_ld, exp_ld, exp_data);
                end
            end
            step();
        end
        $display("test_contention done");
    endtask

    task automatic test_lock();
        preload(14'h0060, 32'hB0B00060);
        do_reset();
        ld_req = 1; ld_we = 1; ld_lock = 1; ld_addr = 14'h0050; ld_wdata = 32'h55;
        @(negedge clk);
        n_checks++;
        if ({ld_gnt, cpu_gnt, locked} !== 3'b100) begin
            n_fail++;
            $display("FAIL lock_enter: got ld/cpu/locked=%b%b%b want 100", ld_gnt, cpu_gnt, locked);
        end
        step();
        for (int i = 1; i < 3; i++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0060;
            ld_addr = 14'h0050 + AW'(i);
            @(negedge clk);
            n_checks++;
            if ({ld_gnt, cpu_gnt, locked} !== 3'b101) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got ld/cpu/locked=%b%b%b want 101",
                         i, ld_gnt, cpu_gnt, locked);
            end
            step();
        end
        ld_req = 0; ld_we = 0; ld_lock = 0;
        @(negedge clk);
        n_checks++;
        if ({ld_gnt, cpu_gnt, locked} !== 3'b011) begin
            n_fail++;
            $display("FAIL lock_exit: got ld/cpu/locked=%b%b%b want 011", ld_gnt, cpu_gnt, locked);
        end
        step();
        cpu_req = 0; ld_lock = 1;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, locked, cpu_rvalid} !== 3'b000) begin
            n_fail++;
            $display("FAIL lock_released: got gnt/locked/rv=%b%b%b want 000", cpu_gnt, locked, cpu_rvalid);
        end
        step();
        cpu_req = 1; cpu_addr = 14'h0060;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, locked, cpu_rvalid, cpu_rdata} !== {3'b101, 32'hB0B00060}) begin
            n_fail++;
            $display("FAIL lock_no_req: got gnt/locked/rv=%b%b%b rd=%h want 101 b0b00060",
                     cpu_gnt, locked, cpu_rvalid, cpu_rdata);
        end
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_w/o_req_state: got locked=%b want 0", locked);
        end
        step();
        $display("test_lock done");
    endtask

    task automatic test_reset_midop();
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h0010;
        @(negedge clk);
        n_checks++;
        if (cpu_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_gnt: got %b want 1", cpu_gnt);
        end
        step();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, ld_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_c1: got rvalid=%b%b want 00", cpu_rvalid, ld_rvalid);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_we, locked, mem_addr, mem_wdata, cpu_rdata, ld_rdata} !== '0) begin
            n_fail++;
            $display("FAIL midrst_c2: got flags=%b%b%b%b%b%b addr=%h wd=%h crd=%h lrd=%h want all 0",
                     cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_we, locked,
                     mem_addr, mem_wdata, cpu_rdata, ld_rdata);
        end
        step();
        @(negedge clk);
        n_checks++;
        if ({cpu_rvalid, ld_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL midrst_c3: got rvalid=%b%b want 00", cpu_rvalid, ld_rvalid);
        end
        step();
        $display("test_reset_midop done");
    endtask

    task automatic test_idle_hold();
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h0100; cpu_wdata = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++;
        if ({cpu_gnt, mem_we, mem_addr} !== {2'b11, 14'h0100}) begin
            n_fail++;
            $display("FAIL idle_access: got gnt=%b we=%b addr=%h want 1 1 0100", cpu_gnt, mem_we, mem_addr);
        end
        step();
        clear_inputs();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mem_we, cpu_rvalid, ld_rvalid, mem_addr, mem_wdata} !== {3'b000, 14'h0100, 32'hCAFEF00D}) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got we=%b rv=%b%b addr=%h wd=%h want 0 00 0100 cafef00d",
                         i, mem_we, cpu_rvalid, ld_rvalid, mem_addr, mem_wdata);
            end
            step();
        end
        $display("test_idle_hold done");
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_write_then_read();
        test_contention();
        test_lock();
        test_reset_midop();
        test_idle_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
